ula_arbiter: RTL and testbench

Shares the team's single combinational 6-bit ALU between two requesters using a valid/ready handshake. It arbitrates round-robin, captures the winning operation and drives the ALU from registers. It registers the 7-bit result with its carry and zero flags, then returns the result on a response channel tagged with the requester id and the requester's tag. The block sits between the two operation sources (sequencer or host) and the ALU datapath.

---
 rtl/ula_ctrl_pkg.sv | 46 ++++
 rtl/ula_arbiter_if.sv | 45 ++++
 rtl/rr_arb2.sv | 23 ++
 rtl/ula.sv | 56 +++++
 rtl/ula_arbiter.sv | 144 ++++++++++++++
 tb/tb_ula_arbiter.sv | 231 +++++++++++++++++++++++
 6 files changed

// File: rtl/ula_ctrl_pkg.sv
// Shared types and constants for the ULA request arbiter and its ALU.
package ula_ctrl_pkg;

    localparam int unsigned W     = 6;
    localparam int unsigned TAG_W = 2;
    localparam int unsigned RES_W = 7;
    localparam int unsigned CNT_W = 8;

    typedef enum logic [1:0] {
        IDLE = 2'd0,
        EXEC = 2'd1,
        RESP = 2'd2
    } state_t;

    localparam logic MODE_ARITH = 1'b0;
    localparam logic MODE_LOGIC = 1'b1;

    // Arithmetic-mode op codes
    localparam logic [2:0] OP_ADD    = 3'd0;
    localparam logic [2:0] OP_SUB    = 3'd1;
    localparam logic [2:0] OP_ADD_NB = 3'd2;
    localparam logic [2:0] OP_SUB_NB = 3'd3;
    localparam logic [2:0] OP_INC_A  = 3'd4;
    localparam logic [2:0] OP_DEC_A  = 3'd5;
    localparam logic [2:0] OP_INC_B  = 3'd6;
    localparam logic [2:0] OP_DEC_B  = 3'd7;

    // Logic-mode op codes
    localparam logic [2:0] OP_AND    = 3'd0;
    localparam logic [2:0] OP_NOT_A  = 3'd1;
    localparam logic [2:0] OP_NOT_B  = 3'd2;
    localparam logic [2:0] OP_OR     = 3'd3;
    localparam logic [2:0] OP_XOR    = 3'd4;
    localparam logic [2:0] OP_NAND   = 3'd5;
    localparam logic [2:0] OP_PASS_A = 3'd6;
    localparam logic [2:0] OP_PASS_B = 3'd7;

    typedef struct packed {
        logic [W-1:0]     a;
        logic [W-1:0]     b;
        logic             modo;
        logic [2:0]       op;
        logic [TAG_W-1:0] tag;
    } alu_req_t;

endpackage

// File: rtl/ula_arbiter_if.sv
// Two request channels and one response channel of the ULA arbiter.
interface ula_arbiter_if;
    import ula_ctrl_pkg::*;

    logic             req0_valid;
    logic             req0_ready;
    logic [W-1:0]     req0_a;
    logic [W-1:0]     req0_b;
    logic             req0_modo;
    logic [2:0]       req0_op;
    logic [TAG_W-1:0] req0_tag;

    logic             req1_valid;
    logic             req1_ready;
    logic [W-1:0]     req1_a;
    logic [W-1:0]     req1_b;
    logic             req1_modo;
    logic [2:0]       req1_op;
    logic [TAG_W-1:0] req1_tag;

    logic             rsp_valid;
    logic             rsp_ready;
    logic             rsp_id;
    logic [TAG_W-1:0] rsp_tag;
    logic [RES_W-1:0] rsp_result;
    logic             rsp_co;
    logic             rsp_zero;

    modport master (
        output req0_valid, req0_a, req0_b, req0_modo, req0_op, req0_tag,
        output req1_valid, req1_a, req1_b, req1_modo, req1_op, req1_tag,
        output rsp_ready,
        input  req0_ready, req1_ready,
        input  rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_co, rsp_zero
    );

    modport slave (
        input  req0_valid, req0_a, req0_b, req0_modo, req0_op, req0_tag,
        input  req1_valid, req1_a, req1_b, req1_modo, req1_op, req1_tag,
        input  rsp_ready,
        output req0_ready, req1_ready,
        output rsp_valid, rsp_id, rsp_tag, rsp_result, rsp_co, rsp_zero
    );

endinterface

// File: rtl/rr_arb2.sv
// Two-way round-robin arbiter; grant is only issued while advance is high.
module rr_arb2 (
    input  logic [1:0] req,
    input  logic       last,
    input  logic       advance,
    output logic [1:0] grant,
    output logic       grant_id
);

    always_comb begin
        grant    = 2'b00;
        grant_id = 1'b0;
        if (req == 2'b11) begin
            grant_id = ~last;
        end else begin
            grant_id = req[1];
        end
        if (advance && (req != 2'b00)) begin
            grant = grant_id ? 2'b10 : 2'b01;
        end
    end

endmodule

// File: rtl/ula.sv
// Combinational 6-bit ALU with 7-bit result, carry (result > 63) and zero flags.
module ula
    import ula_ctrl_pkg::*;
(
    input  logic [W-1:0]     A,
    input  logic [W-1:0]     B,
    input  logic             modo,
    input  logic [2:0]       op,
    input  logic             reset,
    output logic [RES_W-1:0] otULA,
    output logic             Co,
    output logic             zero
);

    logic [RES_W-1:0] w_a;
    logic [RES_W-1:0] w_b;

    assign w_a = RES_W'(A);
    assign w_b = RES_W'(B);

    // Complements are taken at the full 7-bit result width
    always_comb begin
        otULA = '0;
        if (!reset) begin
            if (modo == MODE_ARITH) begin
                case (op)
                    OP_ADD:    otULA = w_a + w_b;
                    OP_SUB:    otULA = w_a - w_b;
                    OP_ADD_NB: otULA = w_a + ~w_b;
                    OP_SUB_NB: otULA = w_a - ~w_b;
                    OP_INC_A:  otULA = w_a + RES_W'(1);
                    OP_DEC_A:  otULA = w_a - RES_W'(1);
                    OP_INC_B:  otULA = w_b + RES_W'(1);
                    OP_DEC_B:  otULA = w_b - RES_W'(1);
                    default:   otULA = '0;
                endcase
            end else begin
                case (op)
                    OP_AND:    otULA = w_a & w_b;
                    OP_NOT_A:  otULA = ~w_a;
                    OP_NOT_B:  otULA = ~w_b;
                    OP_OR:     otULA = w_a | w_b;
                    OP_XOR:    otULA = w_a ^ w_b;
                    OP_NAND:   otULA = ~(w_a & w_b);
                    OP_PASS_A: otULA = w_a;
                    OP_PASS_B: otULA = w_b;
                    default:   otULA = '0;
                endcase
            end
        end
    end

    assign Co   = otULA[RES_W-1];
    assign zero = (otULA == '0);

endmodule

// File: rtl/ula_arbiter.sv
// Shares one ALU between two requesters: round-robin grant, one-cycle execute,
// then a held response tagged with requester id and tag.
module ula_arbiter
    import ula_ctrl_pkg::*;
(
    input  logic             clk,
    input  logic             reset,
    ula_arbiter_if.slave     bus,
    output logic             busy,
    output logic [CNT_W-1:0] done_cnt
);

    state_t           r_state;
    state_t           w_state_nxt;
    alu_req_t         r_req;
    alu_req_t         w_sel;
    logic             r_id;
    logic             r_last;
    logic [RES_W-1:0] r_result;
    logic             r_co;
    logic             r_zero;
    logic [CNT_W-1:0] r_done_cnt;

    logic [1:0]       w_grant;
    logic             w_grant_id;
    logic             w_arb_en;
    logic             w_accept;
    logic             w_rsp_hs;
    logic [RES_W-1:0] w_alu_result;
    logic             w_alu_co;
    logic             w_alu_zero;

    // Arbiter only grants in IDLE and never while reset is held
    assign w_arb_en = (r_state == IDLE) && !reset;

    rr_arb2 u_arb (
        .req      ({bus.req1_valid, bus.req0_valid}),
        .last     (r_last),
        .advance  (w_arb_en),
        .grant    (w_grant),
        .grant_id (w_grant_id)
    );

    always_comb begin
        w_sel = '0;
        if (w_grant_id) begin
            w_sel.a    = bus.req1_a;
            w_sel.b    = bus.req1_b;
            w_sel.modo = bus.req1_modo;
            w_sel.op   = bus.req1_op;
            w_sel.tag  = bus.req1_tag;
        end else begin
            w_sel.a    = bus.req0_a;
            w_sel.b    = bus.req0_b;
            w_sel.modo = bus.req0_modo;
            w_sel.op   = bus.req0_op;
            w_sel.tag  = bus.req0_tag;
        end
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_state <= IDLE;
        end else begin
            r_state <= w_state_nxt;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        w_accept    = 1'b0;
        w_rsp_hs    = 1'b0;
        case (r_state)
            IDLE: begin
                if (w_grant != 2'b00) begin
                    w_accept    = 1'b1;
                    w_state_nxt = EXEC;
                end
            end
            EXEC: begin
                w_state_nxt = RESP;
            end
            RESP: begin
                if (bus.rsp_ready) begin
                    w_rsp_hs    = 1'b1;
                    w_state_nxt = IDLE;
                end
            end
            default: begin
                w_state_nxt = IDLE;
            end
        endcase
    end

    // Captured operation, ALU result and completion count
    always_ff @(posedge clk) begin
        if (reset) begin
            r_req      <= '0;
            r_id       <= 1'b0;
            r_last     <= 1'b1;
            r_result   <= '0;
            r_co       <= 1'b0;
            r_zero     <= 1'b0;
            r_done_cnt <= '0;
        end else begin
            if (w_accept) begin
                r_req  <= w_sel;
                r_id   <= w_grant_id;
                r_last <= w_grant_id;
            end
            if (r_state == EXEC) begin
                r_result <= w_alu_result;
                r_co     <= w_alu_co;
                r_zero   <= w_alu_zero;
            end
            if (w_rsp_hs) begin
                r_done_cnt <= r_done_cnt + CNT_W'(1);
            end
        end
    end

    ula u_ula (
        .A     (r_req.a),
        .B     (r_req.b),
        .modo  (r_req.modo),
        .op    (r_req.op),
        .reset (1'b0),
        .otULA (w_alu_result),
        .Co    (w_alu_co),
        .zero  (w_alu_zero)
    );

    assign bus.req0_ready = w_grant[0];
    assign bus.req1_ready = w_grant[1];
    assign bus.rsp_valid  = (r_state == RESP);
    assign bus.rsp_id     = r_id;
    assign bus.rsp_tag    = r_req.tag;
    assign bus.rsp_result = r_result;
    assign bus.rsp_co     = r_co;
    assign bus.rsp_zero   = r_zero;
    assign busy           = (r_state != IDLE);
    assign done_cnt       = r_done_cnt;

endmodule

// File: tb/tb_ula_arbiter.sv
// Directed self-checking bench for ula_arbiter with hand-computed expectations.
module tb_ula_arbiter;
    import ula_ctrl_pkg::*;

    logic       clk;
    logic       reset;
    logic       busy;
    logic [7:0] done_cnt;
    int         n_tests;
    int         n_fail;

    ula_arbiter_if bus ();

    ula_arbiter u_dut (
        .clk      (clk),
        .reset    (reset),
        .bus      (bus),
        .busy     (busy),
        .done_cnt (done_cnt)
    );

    initial clk = 1'b0;
    always #5 clk = ~clk;

    initial begin
        #200000;
        $display("FAIL watchdog: simulation time limit reached");
        $fatal(1, "watchdog");
    end

    task automatic check(input string name, input logic [31:0] got, input logic [31:0] exp);
        n_tests++;
        if (got !== exp) begin
            n_fail++;
            $display("FAIL %s: got 0x%0h expected 0x%0h", name, got, exp);
        end
    endtask

    task automatic tick();
        @(posedge clk);
        @(negedge clk);
    endtask

    task automatic set_req(input logic id, input logic [5:0] a, input logic [5:0] b,
                           input logic modo, input logic [2:0] op, input logic [1:0] tag);
        if (!id) begin
            bus.req0_a = a; bus.req0_b = b; bus.req0_modo = modo;
            bus.req0_op = op; bus.req0_tag = tag; bus.req0_valid = 1'b1;
        end else begin
            bus.req1_a = a; bus.req1_b = b; bus.req1_modo = modo;
            bus.req1_op = op; bus.req1_tag = tag; bus.req1_valid = 1'b1;
        end
    endtask

    task automatic clr_req();
        bus.req0_valid = 1'b0;
        bus.req1_valid = 1'b0;
    endtask

    // One full transaction from a single requester, starting at a negedge in IDLE
    task automatic do_op(input logic id, input logic [5:0] a, input logic [5:0] b,
                         input logic modo, input logic [2:0] op, input logic [1:0] tag,
                         input logic [6:0] e_res, input logic e_co, input logic e_zero,
                         input logic [7:0] e_done);
        bus.rsp_ready = 1'b0;
        set_req(id, a, b, modo, op, tag);
        #1;
        check("op_ready_grant", 32'(id ? bus.req1_ready : bus.req0_ready), 32'd1);
        check("op_ready_other", 32'(id ? bus.req0_ready : bus.req1_ready), 32'd0);
        tick();
        clr_req();
        #1;
        check("op_exec_busy", 32'(busy), 32'd1);
        check("op_exec_novalid", 32'(bus.rsp_valid), 32'd0);
        tick();
        #1;
        check("op_rsp_valid", 32'(bus.rsp_valid), 32'd1);
        check("op_rsp_result", 32'(bus.rsp_result), 32'(e_res));
        check("op_rsp_co", 32'(bus.rsp_co), 32'(e_co));
        check("op_rsp_zero", 32'(bus.rsp_zero), 32'(e_zero));
        check("op_rsp_id", 32'(bus.rsp_id), 32'(id));
        check("op_rsp_tag", 32'(bus.rsp_tag), 32'(tag));
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        check("op_rsp_drop", 32'(bus.rsp_valid), 32'd0);
        check("op_done_cnt", 32'(done_cnt), 32'(e_done));
    endtask

    initial begin
        n_tests = 0;
        n_fail  = 0;
        reset   = 1'b1;
        bus.rsp_ready = 1'b0;
        bus.req0_valid = 1'b0; bus.req0_a = '0; bus.req0_b = '0;
        bus.req0_modo = 1'b0; bus.req0_op = '0; bus.req0_tag = '0;
        bus.req1_valid = 1'b0; bus.req1_a = '0; bus.req1_b = '0;
        bus.req1_modo = 1'b0; bus.req1_op = '0; bus.req1_tag = '0;
        tick();

        // Reset held with random inputs
        for (int c = 0; c < 3; c++) begin
            bus.req0_valid = 1'($urandom); bus.req1_valid = 1'($urandom);
            bus.req0_a = 6'($urandom); bus.req0_b = 6'($urandom);
            bus.req1_a = 6'($urandom); bus.req1_b = 6'($urandom);
            bus.req0_op = 3'($urandom); bus.req1_op = 3'($urandom);
            bus.req0_tag = 2'($urandom); bus.req1_tag = 2'($urandom);
            bus.rsp_ready = 1'($urandom);
            #1;
            check("rst_rsp_valid", 32'(bus.rsp_valid), 32'd0);
            check("rst_ready0", 32'(bus.req0_ready), 32'd0);
            check("rst_ready1", 32'(bus.req1_ready), 32'd0);
            check("rst_busy", 32'(busy), 32'd0);
            check("rst_done_cnt", 32'(done_cnt), 32'd0);
            check("rst_result", 32'(bus.rsp_result), 32'd0);
            check("rst_flags", 32'({bus.rsp_co, bus.rsp_zero, bus.rsp_id, bus.rsp_tag}), 32'd0);
            tick();
        end
        reset = 1'b0;
        clr_req();
        bus.rsp_ready = 1'b0;

        // Basic add from requester 0
        do_op(1'b0, 6'd5, 6'd3, MODE_ARITH, OP_ADD, 2'd1, 7'd8, 1'b0, 1'b0, 8'd1);

        // Flag boundaries and logic mode from requester 1
        do_op(1'b1, 6'd63, 6'd1, MODE_ARITH, OP_ADD, 2'd0, 7'd64, 1'b1, 1'b0, 8'd2);
        do_op(1'b1, 6'd5, 6'd5, MODE_ARITH, OP_SUB, 2'd1, 7'd0, 1'b0, 1'b1, 8'd3);
        do_op(1'b1, 6'h2A, 6'h0F, MODE_LOGIC, OP_AND, 2'd2, 7'h0A, 1'b0, 1'b0, 8'd4);
        do_op(1'b1, 6'h05, 6'h00, MODE_LOGIC, OP_NOT_A, 2'd3, 7'h7A, 1'b1, 1'b0, 8'd5);
        do_op(1'b1, 6'd3, 6'd1, MODE_ARITH, OP_SUB_NB, 2'd0, 7'd5, 1'b0, 1'b0, 8'd6);

        // Both requesters continuously valid: alternate grants every 3 cycles
        set_req(1'b0, 6'd1, 6'd2, MODE_ARITH, OP_ADD, 2'd2);
        set_req(1'b1, 6'd9, 6'd4, MODE_ARITH, OP_SUB, 2'd3);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 12; c++) begin
            #1;
            check("rr_ready0", 32'(bus.req0_ready), 32'((c % 3 == 0) && ((c / 3) % 2 == 0)));
            check("rr_ready1", 32'(bus.req1_ready), 32'((c % 3 == 0) && ((c / 3) % 2 == 1)));
            if (c % 3 == 2) begin
                check("rr_rsp_valid", 32'(bus.rsp_valid), 32'd1);
                check("rr_rsp_id", 32'(bus.rsp_id), 32'((c / 3) % 2));
                check("rr_rsp_result", 32'(bus.rsp_result), ((c / 3) % 2 == 1) ? 32'd5 : 32'd3);
                check("rr_rsp_tag", 32'(bus.rsp_tag), ((c / 3) % 2 == 1) ? 32'd3 : 32'd2);
            end
            tick();
        end
        clr_req();
        bus.rsp_ready = 1'b0;
        #1;
        check("rr_done_cnt", 32'(done_cnt), 32'd10);
        check("rr_idle", 32'(busy), 32'd0);

        // Response backpressure with requester 0 waiting
        set_req(1'b1, 6'd2, 6'd2, MODE_LOGIC, OP_AND, 2'd1);
        #1;
        check("bp_ready1", 32'(bus.req1_ready), 32'd1);
        tick();
        clr_req();
        tick();
        set_req(1'b0, 6'd3, 6'd4, MODE_ARITH, OP_ADD, 2'd0);
        for (int c = 0; c < 5; c++) begin
            #1;
            check("bp_rsp_valid", 32'(bus.rsp_valid), 32'd1);
            check("bp_rsp_result", 32'(bus.rsp_result), 32'd2);
            check("bp_rsp_id_tag", 32'({bus.rsp_id, bus.rsp_tag}), 32'b101);
            check("bp_ready0_low", 32'(bus.req0_ready), 32'd0);
            tick();
        end
        bus.rsp_ready = 1'b1;
        #1;
        check("bp_ready0_hs", 32'(bus.req0_ready), 32'd0);
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        check("bp_rsp_drop", 32'(bus.rsp_valid), 32'd0);
        check("bp_done_cnt", 32'(done_cnt), 32'd11);
        check("bp_ready0_next", 32'(bus.req0_ready), 32'd1);
        tick();
        clr_req();
        #1;
        check("bp_exec_busy", 32'(busy), 32'd1);
        tick();
        #1;
        check("bp_rsp2_valid", 32'(bus.rsp_valid), 32'd1);
        check("bp_rsp2_result", 32'(bus.rsp_result), 32'd7);
        check("bp_rsp2_id", 32'(bus.rsp_id), 32'd0);
        bus.rsp_ready = 1'b1;
        tick();
        bus.rsp_ready = 1'b0;
        #1;
        check("bp_done_cnt2", 32'(done_cnt), 32'd12);

        // Reset during EXEC discards the operation
        set_req(1'b0, 6'd1, 6'd1, MODE_ARITH, OP_ADD, 2'd0);
        #1;
        check("rx_ready0", 32'(bus.req0_ready), 32'd1);
        tick();
        clr_req();
        #1;
        check("rx_exec_busy", 32'(busy), 32'd1);
        reset = 1'b1;
        tick();
        reset = 1'b0;
        #1;
        check("rx_busy", 32'(busy), 32'd0);
        check("rx_rsp_valid", 32'(bus.rsp_valid), 32'd0);
        check("rx_done_cnt", 32'(done_cnt), 32'd0);
        bus.rsp_ready = 1'b1;
        for (int c = 0; c < 4; c++) begin
            tick();
            #1;
            check("rx_no_rsp", 32'(bus.rsp_valid), 32'd0);
            check("rx_done_hold", 32'(done_cnt), 32'd0);
        end
        bus.rsp_ready = 1'b0;
        set_req(1'b0, 6'd0, 6'd0, MODE_ARITH, OP_ADD, 2'd0);
        set_req(1'b1, 6'd0, 6'd0, MODE_ARITH, OP_ADD, 2'd0);
        #1;
        check("rx_ptr_ready0", 32'(bus.req0_ready), 32'd1);
        check("rx_ptr_ready1", 32'(bus.req1_ready), 32'd0);
        clr_req();
        do_op(1'b1, 6'h30, 6'h0C, MODE_LOGIC, OP_OR, 2'd2, 7'h3C, 1'b0, 1'b0, 8'd1);

        $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
        $finish;
    end

endmodule
